// File: rtl/usb_attach_ctrl_if.sv
// Control/status bundle between the attach sequencer and the SoC top.
// Latency: none (wires only).
// Backpressure: none; level signals only.
interface usb_attach_ctrl_if;
  logic       sleep_i;
  logic       dp_pu_i;
  logic       reconnect_i;
  logic       usb_rstn_o;
  logic       pu_en_o;
  logic       led_o;
  logic [2:0] state_o;

  modport master (
    output sleep_i, dp_pu_i, reconnect_i,
    input  usb_rstn_o, pu_en_o, led_o, state_o
  );

  modport slave (
    input  sleep_i, dp_pu_i, reconnect_i,
    output usb_rstn_o, pu_en_o, led_o, state_o
  );
endinterface

// File: rtl/usb_attach_ctrl.sv
// USB power-up/attach/suspend/detach sequencer with LED pattern; USB_ATTACH_WDOG_EN adds ATTACH watchdog.
// Latency: input pin to registered output in 3 clk_1mhz cycles (2-flop sync + state register).
// Backpressure: none; reconnect acts on its synchronized rising edge only.
module usb_attach_ctrl #(
  parameter int CNT_W           = 21,
  parameter int STARTUP_US      = 1000,
  parameter int DETACH_US       = 100000,
  parameter int SUSPEND_FILT_US = 3000,
  parameter int BLINK_LOG2      = 17,
  parameter int WDOG_US         = 1000000
) (
  input  logic              clk_1mhz,
  input  logic              rstn,
  usb_attach_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    ATTACH     = 3'd1,
    ACTIVE     = 3'd2,
    SUSPEND    = 3'd3,
    DETACH     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_US - 1);
  localparam logic [CNT_W-1:0] DETACH_LAST  = CNT_W'(DETACH_US - 1);
  localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(SUSPEND_FILT_US - 1);
  localparam int               BW           = BLINK_LOG2 + 3;

  logic sleep_m, sleep_s, dp_m, dp_s, rc_m, rc_s, rc_d;
  logic rc_edge;

  state_t            state, nxt;
  logic [CNT_W-1:0]  timer, tmr_inc, tmr_nxt;
  logic [BW-1:0]     blink_cnt, blink_nxt;
  logic              usb_rstn_r, pu_en_r, led_r;
  logic              usb_rstn_nxt, led_nxt;

  always_ff @(posedge clk_1mhz or negedge rstn) begin
    if (!rstn) begin
      sleep_m <= 1'b0;
      sleep_s <= 1'b0;
      dp_m    <= 1'b0;
      dp_s    <= 1'b0;
      rc_m    <= 1'b0;
      rc_s    <= 1'b0;
      rc_d    <= 1'b0;
    end else begin
      sleep_m <= bus.sleep_i;
      sleep_s <= sleep_m;
      dp_m    <= bus.dp_pu_i;
      dp_s    <= dp_m;
      rc_m    <= bus.reconnect_i;
      rc_s    <= rc_m;
      rc_d    <= rc_s;
    end
  end

  assign rc_edge   = rc_s & ~rc_d;
  assign tmr_inc   = (&timer) ? timer : timer + 1'b1;
  assign blink_nxt = blink_cnt + 1'b1;

`ifdef USB_ATTACH_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_US - 1);
  logic wd_det, wd_trip;
`endif

  always_comb begin
    nxt     = state;
    tmr_nxt = tmr_inc;
`ifdef USB_ATTACH_WDOG_EN
    wd_trip = 1'b0;
`endif
    case (state)
      RESET_HOLD: if (timer == STARTUP_LAST) nxt = ATTACH;
      ATTACH: begin
        if (rc_edge)    nxt = DETACH;
        else if (dp_s)  nxt = ACTIVE;
`ifdef USB_ATTACH_WDOG_EN
        else if (timer == WDOG_LAST) begin
          nxt     = DETACH;
          wd_trip = 1'b1;
        end
`else
        tmr_nxt = '0;
`endif
      end
      ACTIVE: begin
        if (rc_edge)      nxt = DETACH;
        else if (!dp_s)   nxt = ATTACH;
        else if (!sleep_s) tmr_nxt = '0;
        else if (timer == FILT_LAST) nxt = SUSPEND;
      end
      SUSPEND: begin
        if (rc_edge)       nxt = DETACH;
        else if (!dp_s)    nxt = ATTACH;
        else if (!sleep_s) nxt = ACTIVE;
      end
      DETACH:  if (timer == DETACH_LAST) nxt = ATTACH;
      default: nxt = RESET_HOLD;
    endcase
    if (nxt != state) tmr_nxt = '0;
  end

  // Outputs are computed from the next state so they land in the same cycle as state_o.
  always_comb begin
    usb_rstn_nxt = (nxt != RESET_HOLD);
`ifdef USB_ATTACH_WDOG_EN
    if (nxt == DETACH && ((nxt != state) ? wd_trip : wd_det) && tmr_nxt < CNT_W'(16))
      usb_rstn_nxt = 1'b0;
`endif
    case (nxt)
      ATTACH:  led_nxt = blink_nxt[BLINK_LOG2];
      ACTIVE:  led_nxt = 1'b1;
      SUSPEND: led_nxt = (blink_nxt[BW-1:BLINK_LOG2] == 3'd0);
      default: led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_1mhz or negedge rstn) begin
    if (!rstn) begin
      state      <= RESET_HOLD;
      timer      <= '0;
      blink_cnt  <= '0;
      usb_rstn_r <= 1'b0;
      pu_en_r    <= 1'b0;
      led_r      <= 1'b0;
    end else begin
      state      <= nxt;
      timer      <= tmr_nxt;
      blink_cnt  <= blink_nxt;
      usb_rstn_r <= usb_rstn_nxt;
      pu_en_r    <= (nxt == ATTACH) || (nxt == ACTIVE) || (nxt == SUSPEND);
      led_r      <= led_nxt;
    end
  end

`ifdef USB_ATTACH_WDOG_EN
  always_ff @(posedge clk_1mhz or negedge rstn) begin
    if (!rstn)              wd_det <= 1'b0;
    else if (nxt != state)  wd_det <= wd_trip;
  end
`endif

  assign bus.usb_rstn_o = usb_rstn_r;
  assign bus.pu_en_o    = pu_en_r;
  assign bus.led_o      = led_r;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_usb_attach_ctrl.sv
// Bench for usb_attach_ctrl with shortened timing parameters and a cycle-level reference model.
module tb_usb_attach_ctrl;
  localparam int STARTUP = 20;
  localparam int DETACH  = 60;
  localparam int FILT    = 30;
  localparam int BL      = 3;
  localparam int WDOG    = 200;

  logic clk_1mhz;
  logic rstn;
  usb_attach_ctrl_if bus();

  usb_attach_ctrl #(
    .CNT_W(21), .STARTUP_US(STARTUP), .DETACH_US(DETACH),
    .SUSPEND_FILT_US(FILT), .BLINK_LOG2(BL), .WDOG_US(WDOG)
  ) dut (
    .clk_1mhz (clk_1mhz),
    .rstn     (rstn),
    .bus      (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk_1mhz = 1'b0;
    forever #5 clk_1mhz = ~clk_1mhz;
  end

  // Reference model: state plus entry cycle; pins seen through a 2-edge delay line.
  int m_st, m_cyc, m_enter, m_run;
  bit m_wd;
  bit h_sl[1:3], h_dp[1:3], h_rc[1:3];

  initial begin
    bit sl, dp, rce, trip;
    int nst, age;
    m_st = 0; m_cyc = 0; m_enter = 0; m_run = 0; m_wd = 0;
    for (int i = 1; i <= 3; i++) begin h_sl[i] = 0; h_dp[i] = 0; h_rc[i] = 0; end
    forever begin
      @(posedge clk_1mhz or negedge rstn);
      if (!rstn) begin
        m_st = 0; m_cyc = 0; m_enter = 0; m_run = 0; m_wd = 0;
        for (int i = 1; i <= 3; i++) begin h_sl[i] = 0; h_dp[i] = 0; h_rc[i] = 0; end
      end else begin
        m_cyc++;
        sl = h_sl[2]; dp = h_dp[2]; rce = h_rc[2] && !h_rc[3];
        age = m_cyc - m_enter;
        nst = m_st; trip = 0;
        case (m_st)
          0: if (age == STARTUP) nst = 1;
          1: begin
            if (rce) nst = 4;
            else if (dp) nst = 2;
`ifdef USB_ATTACH_WDOG_EN
            else if (age == WDOG) begin nst = 4; trip = 1; end
`endif
          end
          2: begin
            if (rce) nst = 4;
            else if (!dp) nst = 1;
            else if (sl) begin m_run++; if (m_run == FILT) nst = 3; end
            else m_run = 0;
          end
          3: begin
            if (rce) nst = 4;
            else if (!dp) nst = 1;
            else if (!sl) nst = 2;
          end
          4: if (age == DETACH) nst = 1;
          default: nst = 0;
        endcase
        if (nst != m_st) begin m_st = nst; m_enter = m_cyc; m_run = 0; m_wd = trip; end
        h_sl[3] = h_sl[2]; h_sl[2] = h_sl[1]; h_sl[1] = bus.sleep_i;
        h_dp[3] = h_dp[2]; h_dp[2] = h_dp[1]; h_dp[1] = bus.dp_pu_i;
        h_rc[3] = h_rc[2]; h_rc[2] = h_rc[1]; h_rc[1] = bus.reconnect_i;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    int e_rstn, e_pu, e_led, ph;
    forever begin
      @(negedge clk_1mhz);
      ph     = (m_cyc >> BL) % 8;
      e_rstn = (m_st != 0) && !(m_wd && m_st == 4 && (m_cyc - m_enter) < 16);
      e_pu   = (m_st >= 1 && m_st <= 3);
      case (m_st)
        1:       e_led = ph % 2;
        2:       e_led = 1;
        3:       e_led = (ph == 0);
        default: e_led = 0;
      endcase
      chk("model_state", int'(bus.state_o), m_st);
      chk("model_usb_rstn", int'(bus.usb_rstn_o), e_rstn);
      chk("model_pu_en", int'(bus.pu_en_o), e_pu);
      chk("model_led", int'(bus.led_o), e_led);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_usb_rstn"}, int'(bus.usb_rstn_o), 0);
    chk({tag, "_pu_en"}, int'(bus.pu_en_o), 0);
    chk({tag, "_led"}, int'(bus.led_o), 0);
    chk({tag, "_state"}, int'(bus.state_o), 0);
  endtask

  initial begin
    int lows, rlows, leds, n4;
    rstn = 1'b0;
    bus.sleep_i = 1'b0; bus.dp_pu_i = 1'b0; bus.reconnect_i = 1'b0;
    repeat (3) @(negedge clk_1mhz);
    chk_zero("reset");
    rstn = 1'b1;

    // Startup hold, then ATTACH in the same cycle usb_rstn rises.
    repeat (STARTUP - 1) @(posedge clk_1mhz);
    #1 chk("startup_hold_rstn", int'(bus.usb_rstn_o), 0);
    @(posedge clk_1mhz);
    #1 chk("startup_rstn_rise", int'(bus.usb_rstn_o), 1);
    chk("startup_pu_en", int'(bus.pu_en_o), 1);
    chk("startup_state", int'(bus.state_o), 1);
    repeat (40) @(negedge clk_1mhz);

    // dp_pu up/down between ATTACH and ACTIVE with 3-cycle latency.
    bus.dp_pu_i = 1'b1;
    repeat (3) @(posedge clk_1mhz);
    #1 chk("dp_up_state", int'(bus.state_o), 2);
    chk("dp_up_led", int'(bus.led_o), 1);
    @(negedge clk_1mhz) bus.dp_pu_i = 1'b0;
    repeat (3) @(posedge clk_1mhz);
    #1 chk("dp_down_state", int'(bus.state_o), 1);
    @(negedge clk_1mhz) bus.dp_pu_i = 1'b1;
    repeat (10) @(negedge clk_1mhz);

    // Suspend filter: one short of the threshold, then the full threshold.
    bus.sleep_i = 1'b1;
    repeat (FILT - 1) @(negedge clk_1mhz);
    bus.sleep_i = 1'b0;
    repeat (10) @(negedge clk_1mhz);
    chk("filt_short_state", int'(bus.state_o), 2);
    bus.sleep_i = 1'b1;
    repeat (FILT + 1) @(posedge clk_1mhz);
    #1 chk("filt_pre_state", int'(bus.state_o), 2);
    @(posedge clk_1mhz);
    #1 chk("suspend_state", int'(bus.state_o), 3);
    repeat (20) @(negedge clk_1mhz);
    leds = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_1mhz);
      if (bus.led_o) leds++;
    end
    chk("suspend_led_duty", leds, 8);
    bus.sleep_i = 1'b0;
    repeat (3) @(posedge clk_1mhz);
    #1 chk("resume_state", int'(bus.state_o), 2);

    // Detach request; a second pulse inside DETACH is ignored.
    @(negedge clk_1mhz) bus.reconnect_i = 1'b1;
    lows = 0; rlows = 0;
    for (int i = 0; i < DETACH + 30; i++) begin
      @(posedge clk_1mhz);
      #1;
      if (!bus.pu_en_o) lows++;
      if (!bus.usb_rstn_o) rlows++;
      if (i == 4 || i == 25) bus.reconnect_i = 1'b0;
      if (i == 20) bus.reconnect_i = 1'b1;
    end
    chk("detach_pu_low_cycles", lows, DETACH);
    chk("detach_rstn_low_cycles", rlows, 0);
    chk("detach_end_state", int'(bus.state_o), 2);

    // Reset during DETACH.
    @(negedge clk_1mhz) bus.reconnect_i = 1'b1;
    repeat (5) @(negedge clk_1mhz);
    bus.reconnect_i = 1'b0;
    repeat (20) @(negedge clk_1mhz);
    chk("pre_reset_detach_state", int'(bus.state_o), 4);
    #2 rstn = 1'b0;
    #1 chk_zero("rst_in_detach");
    @(negedge clk_1mhz) rstn = 1'b1;
    repeat (STARTUP - 1) @(posedge clk_1mhz);
    #1 chk("restart_hold_rstn", int'(bus.usb_rstn_o), 0);
    @(posedge clk_1mhz);
    #1 chk("restart_state", int'(bus.state_o), 1);

    // Reset during SUSPEND.
    repeat (10) @(negedge clk_1mhz);
    bus.sleep_i = 1'b1;
    repeat (FILT + 10) @(negedge clk_1mhz);
    chk("pre_reset_suspend_state", int'(bus.state_o), 3);
    #2 rstn = 1'b0;
    #1 chk_zero("rst_in_suspend");
    bus.sleep_i = 1'b0;
    @(negedge clk_1mhz) rstn = 1'b1;
    repeat (STARTUP + 10) @(negedge clk_1mhz);
    chk("post_suspend_reset_state", int'(bus.state_o), 2);

    // ATTACH with no pull-up request: watchdog detach only when built in.
    bus.dp_pu_i = 1'b0;
    repeat (5) @(negedge clk_1mhz);
    n4 = 0; rlows = 0;
    for (int i = 0; i < 2 * WDOG; i++) begin
      @(negedge clk_1mhz);
      if (bus.state_o == 3'd4) n4++;
      if (!bus.usb_rstn_o) rlows++;
    end
`ifdef USB_ATTACH_WDOG_EN
    chk("wdog_detach_cycles", n4, DETACH);
    chk("wdog_rstn_low_cycles", rlows, 16);
`else
    chk("nowdog_detach_cycles", n4, 0);
    chk("nowdog_rstn_low_cycles", rlows, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
